pipelined_dadda_mac: RTL

Parametrised, pipelined unsigned multiply-accumulate unit and the next generation of the team's combinational 16-bit Dadda multiplier. It splits each operand into halves, registers the four half-width partial products, recombines them, and accumulates a stream of products into a dot-product result. It has a valid/ready handshake on both sides and sits between the operand-fetch logic and the result writeback in the MAC datapath.

---
 rtl/pipelined_dadda_mac.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pipelined_dadda_mac.sv
// Pipelined unsigned multiply-accumulate: half-width partial products, recombination, dot-product accumulation.
// Optional macro MAC_SAT_EN: clamp the accumulator and result to all-ones on overflow instead of wrapping.
module pipelined_dadda_mac #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 2*WIDTH+8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic [15:0]          out_count,
    output logic                 out_ovf
);
    localparam int H = WIDTH/2;

    // Handshake: a term moves in on in_valid && in_ready, a result moves out on out_valid && out_ready.
    logic w_stall;
    logic r_out_valid;
    assign w_stall   = r_out_valid && !out_ready;
    assign in_ready  = !rst && !w_stall;
    assign out_valid = r_out_valid;

    // S1: operand registers
    logic             r_v1, r_last1;
    logic [WIDTH-1:0] r_a1, r_b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
        end else if (!w_stall) begin
            r_v1    <= in_valid && in_ready;
            r_a1    <= in_a;
            r_b1    <= in_b;
            r_last1 <= in_last;
        end
    end

    // S2: four half-width partial products, operands zero-extended so each product is exact at 2H bits
    logic [2*H-1:0] w_al, w_ah, w_bl, w_bh;
    assign w_al = {{H{1'b0}}, r_a1[H-1:0]};
    assign w_ah = {{H{1'b0}}, r_a1[WIDTH-1:H]};
    assign w_bl = {{H{1'b0}}, r_b1[H-1:0]};
    assign w_bh = {{H{1'b0}}, r_b1[WIDTH-1:H]};

    logic           r_v2, r_last2;
    logic [2*H-1:0] r_pll, r_plh, r_phl, r_phh;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2 <= 1'b0;
        end else if (!w_stall) begin
            r_v2    <= r_v1;
            r_last2 <= r_last1;
            r_pll   <= w_al * w_bl;
            r_plh   <= w_al * w_bh;
            r_phl   <= w_ah * w_bl;
            r_phh   <= w_ah * w_bh;
        end
    end

    // S3: recombined product registered, so a last term accepted at edge k lands at edge k+3
    logic [2*WIDTH-1:0] w_prod;
    assign w_prod = {r_phh, r_pll}
                  + {{H{1'b0}}, r_plh, {H{1'b0}}}
                  + {{H{1'b0}}, r_phl, {H{1'b0}}};

    logic               r_v3, r_last3;
    logic [2*WIDTH-1:0] r_prod;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v3 <= 1'b0;
        end else if (!w_stall) begin
            r_v3    <= r_v2;
            r_last3 <= r_last2;
            r_prod  <= w_prod;
        end
    end

    // Accumulation and output register
    logic [ACC_WIDTH-1:0] r_acc;
    logic [15:0]          r_cnt;
    logic                 r_ovf;
    logic [ACC_WIDTH:0]   w_sum;
    logic [ACC_WIDTH-1:0] w_acc_next;
    logic [15:0]          w_cnt_next;
    logic                 w_ovf_next;

    assign w_sum      = {1'b0, r_acc} + {{(ACC_WIDTH+1-2*WIDTH){1'b0}}, r_prod};
    assign w_ovf_next = r_ovf | w_sum[ACC_WIDTH];
    assign w_cnt_next = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
`ifdef MAC_SAT_EN
    assign w_acc_next = w_ovf_next ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
`else
    assign w_acc_next = w_sum[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            out_acc     <= '0;
            out_count   <= '0;
            out_ovf     <= 1'b0;
        end else if (!w_stall) begin
            // Not stalled means either nothing is held or it is being popped this edge
            r_out_valid <= 1'b0;
            if (r_v3) begin
                if (r_last3) begin
                    out_acc     <= w_acc_next;
                    out_count   <= w_cnt_next;
                    out_ovf     <= w_ovf_next;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_ovf       <= 1'b0;
                end else begin
                    r_acc <= w_acc_next;
                    r_cnt <= w_cnt_next;
                    r_ovf <= w_ovf_next;
                end
            end
        end
    end
endmodule
